mac_accumulate_stage: RTL and testbench

- Downstream consumer of the 27x18 / sum-of-9x9 multiplier.
- Collapses the two partial result vectors and the SIMD carry bits into a final product, then accumulates products over a burst delimited by in_last.
- Two-stage pipeline with a valid/ready handshake on both sides.
- Sits between the multiplier output and the PIRDSP output register / cascade path.

---
 rtl/mac_pkg.sv | 30 +++
 rtl/mac_accumulate_stage_lane_adder.sv | 26 ++
 rtl/mac_accumulate_stage.sv | 157 +++++++++++++++
 tb/tb_mac_accumulate_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulate stage: modes, product field
// positions and the sign-extension helper used during product formation.
package mac_pkg;

  localparam logic MODE_27X18   = 1'b0;
  localparam logic MODE_SUM_9X9 = 1'b1;

  localparam int LANE0_MSB = 26;
  localparam int LANE1_LSB = 27;
  localparam int PROD_W    = 45;

  // Working width of sext(); callers size-cast the result to what they need.
  localparam int EXT_W = 64;

  // Replicates value[from_bit] upward to to_width; bits at and above
  // to_width are zero. A to_width below from_bit+1 simply truncates.
  function automatic logic [EXT_W-1:0] sext(input logic [EXT_W-1:0] value,
                                            input int from_bit,
                                            input int to_width);
    logic [EXT_W-1:0] res;
    res = '0;
    for (int i = 0; i < EXT_W; i++) begin
      if (i < to_width) begin
        res[i] = (i <= from_bit) ? value[i] : value[from_bit];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_accumulate_stage_lane_adder.sv
// One accumulator lane: W-bit add with a gated carry-in so two instances can
// be chained into one full-width adder or split into independent SIMD lanes.
module mac_lane_adder #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         carry_en,
  input  logic         is_signed,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  logic [W:0] full;

  // Add, then flag overflow: sign rule for signed data, carry-out otherwise.
  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin & carry_en};
    sum  = full[W-1:0];
    cout = full[W];
    ovf  = is_signed ? ((a[W-1] == b[W-1]) && (sum[W-1] != a[W-1])) : cout;
  end

endmodule

// File: rtl/mac_accumulate_stage.sv
// Two-stage accumulate stage behind the multiplier: S1 collapses the partial
// vectors into a product, S2 accumulates products over an in_last-delimited
// burst and presents the sum on a valid/ready output. ACC_W must be <= 64.
module mac_accumulate_stage
  import mac_pkg::*;
#(
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [44:0]      result_0,
  input  logic [44:0]      result_1,
  input  logic [3:0]       result_SIMD_carry,
  input  logic             mode,
  input  logic             is_signed,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [1:0]       acc_ovf,
  output logic             acc_mode
);

  localparam int LANE_W = ACC_W / 2;

  logic [PROD_W-1:0]           full_sum;
  logic [LANE0_MSB:0]          lo_sum;
  logic [PROD_W-1-LANE1_LSB:0] hi_sum;
  logic [EXT_W-1:0]            p_full_ext, p0_ext, p1_ext;
  logic [ACC_W-1:0]            p_in;

  logic             s1_full, s1_mode, s1_signed, s1_last;
  logic [ACC_W-1:0] s1_p;
  logic             s1_adv, s2_stall;

  logic [ACC_W-1:0] acc;
  logic [1:0]       ovf_run;
  logic             acc_empty;

  logic [LANE_W-1:0] lane0_sum, lane1_sum;
  logic              lane0_cout, lane1_cout_unused;
  logic              lane0_ovf, lane1_ovf;
  logic [ACC_W-1:0]  acc_sum;
  logic [1:0]        add_ovf, ovf_next;

  // The last product of a burst may not overwrite a result still waiting downstream.
  assign s2_stall = out_valid && !out_ready && s1_full && s1_last;
  assign s1_adv   = s1_full && !s2_stall;
  assign in_ready = !s1_full || s1_adv;

  // Product formation: full-width sum in 27x18 mode, two carry-augmented lanes in SIMD mode.
  always_comb begin
    full_sum   = result_0 + result_1;
    lo_sum     = result_0[LANE0_MSB:0] + result_1[LANE0_MSB:0];
    hi_sum     = result_0[PROD_W-1:LANE1_LSB] + result_1[PROD_W-1:LANE1_LSB];
    p_full_ext = EXT_W'(full_sum);
    p0_ext     = EXT_W'({result_SIMD_carry[1:0], lo_sum});
    p1_ext     = EXT_W'({result_SIMD_carry[3:2], hi_sum});
    if (is_signed) begin
      p_full_ext = sext(p_full_ext, PROD_W - 1, ACC_W);
      p0_ext     = sext(p0_ext, LANE0_MSB + 2, LANE_W);
      p1_ext     = sext(p1_ext, PROD_W - LANE1_LSB + 1, LANE_W);
    end
    if (mode == MODE_SUM_9X9) begin
      p_in = {LANE_W'(p1_ext), LANE_W'(p0_ext)};
    end else begin
      p_in = ACC_W'(p_full_ext);
    end
  end

  // S1 register: single-entry buffer refilled whenever it empties or advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_full   <= 1'b0;
      s1_p      <= '0;
      s1_mode   <= 1'b0;
      s1_signed <= 1'b0;
      s1_last   <= 1'b0;
    end else if (in_ready) begin
      s1_full <= in_valid;
      if (in_valid) begin
        s1_p      <= p_in;
        s1_mode   <= mode;
        s1_signed <= is_signed;
        s1_last   <= in_last;
      end
    end
  end

  mac_lane_adder #(.W(LANE_W)) u_lane0 (
    .a         (acc[LANE_W-1:0]),
    .b         (s1_p[LANE_W-1:0]),
    .cin       (1'b0),
    .carry_en  (1'b1),
    .is_signed (s1_signed),
    .sum       (lane0_sum),
    .cout      (lane0_cout),
    .ovf       (lane0_ovf)
  );

  // Lane1 takes lane0's carry only in 27x18 mode, making a single ACC_W adder.
  mac_lane_adder #(.W(LANE_W)) u_lane1 (
    .a         (acc[ACC_W-1:LANE_W]),
    .b         (s1_p[ACC_W-1:LANE_W]),
    .cin       (lane0_cout),
    .carry_en  (s1_mode == MODE_27X18),
    .is_signed (s1_signed),
    .sum       (lane1_sum),
    .cout      (lane1_cout_unused),
    .ovf       (lane1_ovf)
  );

  // Select the running sum and sticky overflow; a burst start takes the product as-is.
  always_comb begin
    acc_sum = {lane1_sum, lane0_sum};
    add_ovf = (s1_mode == MODE_SUM_9X9) ? {lane1_ovf, lane0_ovf} : {1'b0, lane1_ovf};
    if (acc_empty) begin
      acc_sum  = s1_p;
      ovf_next = 2'b00;
    end else begin
      ovf_next = ovf_run | add_ovf;
    end
  end

  // S2: accumulate, publish on in_last, and hold the output until it is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      ovf_run   <= 2'b00;
      acc_empty <= 1'b1;
      out_valid <= 1'b0;
      acc_out   <= '0;
      acc_ovf   <= 2'b00;
      acc_mode  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (s1_adv) begin
        if (s1_last) begin
          out_valid <= 1'b1;
          acc_out   <= acc_sum;
          acc_ovf   <= ovf_next;
          acc_mode  <= s1_mode;
          acc_empty <= 1'b1;
        end else begin
          acc       <= acc_sum;
          ovf_run   <= ovf_next;
          acc_empty <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulate_stage.sv
// Directed bench for mac_accumulate_stage with a queue-based scoreboard.
module tb_mac_accumulate_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [44:0] result_0, result_1;
  logic [3:0]  carry;
  logic        mode, is_signed, in_last;
  logic        out_valid, out_ready;
  logic [47:0] acc_out;
  logic [1:0]  acc_ovf;
  logic        acc_mode;

  typedef struct packed {
    logic [47:0] acc;
    logic [1:0]  ovf;
    logic        mode;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic bp_done = 1'b0;

  mac_accumulate_stage #(.ACC_W(48)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .result_0          (result_0),
    .result_1          (result_1),
    .result_SIMD_carry (carry),
    .mode              (mode),
    .is_signed         (is_signed),
    .in_last           (in_last),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .acc_out           (acc_out),
    .acc_ovf           (acc_ovf),
    .acc_mode          (acc_mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic push_exp(input logic [47:0] a, input logic [1:0] o, input logic m);
    exp_t e;
    e.acc  = a;
    e.ovf  = o;
    e.mode = m;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [44:0] r0, input logic [44:0] r1, input logic [3:0] c,
                      input logic m, input logic s, input logic l);
    int guard;
    @(negedge clk);
    result_0  = r0;
    result_1  = r1;
    carry     = c;
    mode      = m;
    is_signed = s;
    in_last   = l;
    in_valid  = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, guard);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on each output transfer and checks hold stability.
  initial begin
    exp_t        e;
    logic        hold_prev;
    logic [50:0] held;
    hold_prev = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_stable", {acc_mode, acc_ovf, acc_out}, held);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got acc_out=%0h, expected no output", acc_out);
          end else begin
            e = exp_q.pop_front();
            check("sb_acc_out", acc_out, e.acc);
            check("sb_acc_ovf", acc_ovf, e.ovf);
            check("sb_acc_mode", acc_mode, e.mode);
          end
        end
        hold_prev = out_valid && !out_ready;
        held      = {acc_mode, acc_ovf, acc_out};
      end
    end
  end

  initial begin
    int guard;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    result_0  = '0;
    result_1  = '0;
    carry     = '0;
    mode      = 1'b0;
    is_signed = 1'b0;
    in_last   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_acc_out", acc_out, 48'd0);
    check("rst_acc_ovf", acc_ovf, 2'b00);
    check("rst_acc_mode", acc_mode, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);

    // 27x18 unsigned: 123 + 7, plus output latency
    push_exp(48'd130, 2'b00, 1'b0);
    send(45'd100, 45'd23, 4'd0, 1'b0, 1'b0, 1'b0);
    send(45'd7, 45'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("latency_t1", out_valid, 1'b0);
    @(negedge clk);
    #1;
    check("latency_t2", out_valid, 1'b1);
    wait_drain();

    // 27x18 signed single beat: -1
    push_exp(48'hFFFF_FFFF_FFFF, 2'b00, 1'b0);
    send(45'h1FFF_FFFF_FFFF, 45'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    idle();
    wait_drain();

    // SIMD signed: lane0 = -1, lane1 = 5
    push_exp({24'd5, 24'hFF_FFFF}, 2'b00, 1'b1);
    send({18'd5, 27'h7FF_FFFF}, 45'd0, 4'b0011, 1'b1, 1'b1, 1'b1);
    // then +1 on lane0 must not carry into lane1
    push_exp({24'd5, 24'd0}, 2'b00, 1'b1);
    send({18'd5, 27'h7FF_FFFF}, 45'd0, 4'b0011, 1'b1, 1'b1, 1'b0);
    send({18'd0, 27'd1}, 45'd0, 4'b0000, 1'b1, 1'b1, 1'b1);
    idle();
    wait_drain();

    // SIMD unsigned: 3 x 2^23 in lane0 overflows lane0 only
    push_exp({24'd0, 24'h80_0000}, 2'b01, 1'b1);
    send({18'd0, 27'h80_0000}, 45'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    send({18'd0, 27'h80_0000}, 45'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    send({18'd0, 27'h80_0000}, 45'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    idle();
    wait_drain();

    // 27x18 unsigned: carry crosses the lane boundary
    push_exp(48'h00_0001_00_0000, 2'b00, 1'b0);
    send(45'hFF_FFFF, 45'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    send(45'd1, 45'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle();
    wait_drain();

    // Back-pressure: continuous input while the output waits
    @(negedge clk);
    out_ready = 1'b0;
    push_exp(48'd30, 2'b00, 1'b0);
    push_exp(48'd6, 2'b00, 1'b0);
    push_exp(48'd50, 2'b00, 1'b0);
    fork
      begin
        send(45'd10, 45'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        send(45'd20, 45'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        send(45'd1, 45'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        send(45'd2, 45'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        send(45'd3, 45'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        send(45'd50, 45'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        idle();
        bp_done = 1'b1;
      end
    join_none
    repeat (9) @(negedge clk);
    #1;
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    check("bp_acc_held", acc_out, 48'd30);
    @(negedge clk);
    out_ready = 1'b1;
    guard = 0;
    while (!bp_done && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bp_done) begin
      checks++;
      errors++;
      $display("FAIL bp_sender_timeout: sender still blocked after %0d cycles, expected done", guard);
    end
    wait_drain();

    // Reset mid-burst discards the partial sum
    send(45'd5, 45'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    send(45'd6, 45'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    send(45'd7, 45'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst2_out_valid", out_valid, 1'b0);
    check("rst2_acc_out", acc_out, 48'd0);
    check("rst2_acc_ovf", acc_ovf, 2'b00);
    check("rst2_in_ready", in_ready, 1'b1);
    push_exp(48'd8, 2'b00, 1'b0);
    send(45'd8, 45'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle();
    wait_drain();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
